cfg_layer_mux_array: RTL and testbench
======================================

Name: cfg_layer_mux_array

Overview:
- Next-generation configurable connection-block mux.
- NCH independent output channels. Each channel selects or computes a function of the N-bit input bus through a 5-input LUT tree whose depth is derived from N.
- Configuration is shifted in serially into a shadow store, then atomically committed to the active store, so reprogramming never disturbs live outputs.
- Optional registered outputs. Sits between the routing fabric and logic-block inputs; chains via SIN/SOUT.

Parameters:
- N, 125: inputs per channel; legal range 2..625.
- NCH, 2: number of output channels; legal range 1..16.
- REG_OUT, 0: 0 = Z combinational from the active store; 1 = Z registered, one-cycle latency.
- Derived values:
  - L1 = ceil(N/5); Lk = ceil(L(k-1)/5), repeated until Lk = 1.
  - NLUT = sum of all Lk per channel (N=125 gives 25+5+1 = 31; N=5 gives 1).
  - LEN = NCH*NLUT*32 configuration bits.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RSTN  in  1  synchronous active-low reset.
- A  in  N  data inputs, shared by all channels.
- SIN  in  1  serial configuration data in.
- CE  in  1  shift enable for the shadow store.
- COMMIT  in  1  request copy of shadow to active.
- Z  out  NCH  channel outputs.
- SOUT  out  1  serial configuration data out; equals shadow bit LEN-1, combinational.
- CFG_VALID  out  1  high once any commit has been accepted.
- CFG_ERR  out  1  one-cycle pulse when a commit is rejected.

Behaviour:
- Storage: shadow[LEN-1:0] and active[LEN-1:0], plus a bit counter cnt that saturates at LEN+1.
- Layout of each store:
  - Channel c occupies bits [(c+1)*NLUT*32-1 : c*NLUT*32].
  - Within a channel, LUTs are ordered layer 1 LUT0..L1-1, then layer 2, and so on; the final LUT is last.
  - LUT j of a channel occupies 32 bits at offset j*32.
- LUT evaluation:
  - Output = word[addr].
  - Layer-1 LUT i: addr bit k = A[i*5+k]; indices at or above N read as 0.
  - Layer-m LUT i: addr bit k = output of layer-(m-1) LUT i*5+k; missing LUTs read as 0.
  - Z[c] = final LUT output of channel c, evaluated from active only.
- Shift (CE=1, COMMIT=0): shadow <= {shadow[LEN-2:0], SIN}; cnt <= min(cnt+1, LEN+1). The first bit shifted therefore lands in shadow[LEN-1] after LEN shifts.
- Commit (COMMIT=1):
  - Evaluated on cnt at that edge. CE is ignored in the same cycle; no shift occurs.
  - cnt == LEN: active <= shadow; CFG_VALID <= 1.
  - cnt != LEN (short or overflowed): active unchanged; CFG_ERR pulses 1 for one cycle.
  - cnt <= 0 in both cases. Shadow is never cleared by commit.
- Idle (CE=0, COMMIT=0): all state holds.
- REG_OUT=1: Z register loads the LUT-tree result every cycle. A commit affects Z two edges later: one edge to update active, one edge to register.
- REG_OUT=0: Z changes combinationally after the commit edge.
- Reset (RSTN=0 at an edge):
  - shadow, active and cnt cleared to 0; CFG_VALID=0; CFG_ERR=0; registered Z=0.
  - With active all zero, combinational Z is also 0.
  - Reset mid-shift discards partial configuration; a following commit needs a fresh LEN bits.
  - Reset overrides CE and COMMIT.
- SOUT reflects the shadow store only and is unaffected by commit.

Test Plan:
- N=5, NCH=2, REG_OUT=0 (LEN=64): shift W1=32'hFFFF0000 MSB-first, then W0=32'h00000002 MSB-first, then pulse COMMIT. Required: CFG_VALID=1; Z[1]=A[4]; Z[0]=1 only when A=5'b00001. Sweep all 32 values of A.
- Same configuration as above, then shift a new 64-bit pattern with A held at 5'b10001. Required: Z stays 2'b10 throughout the shift and changes only after COMMIT.
- Short commit: shift 63 bits, then COMMIT. Required: CFG_ERR high for exactly one cycle; active and Z unchanged; CFG_VALID unchanged. Overflow commit: shift 65 bits, then COMMIT. Required: same rejection.
- SOUT: shift 64 bits starting with a 1, then 63 zeros, then continue shifting zeros. Required: SOUT=1 right after the 64th shift and 0 after the 65th.
- N=125, NCH=1, REG_OUT=1 (LEN=992):
  - Program layer-1 LUTs as 5:1 muxes and the upper layers to route input 37; commit.
  - Required: Z tracks A[37] with exactly one cycle of latency.
  - Assert CE and COMMIT together. Required: no shift occurs.
- Assert RSTN=0 after 30 of 64 shift bits, release, shift 34 bits, then COMMIT. Required: rejected with CFG_ERR; Z=0; CFG_VALID=0.

Source files
------------

// File: rtl/cfg_layer_mux_array.sv
// Configurable connection-block mux: NCH channels, each a tree of 5-input
// LUTs over the shared A bus. Configuration is shifted serially into a
// shadow store and copied atomically into the active store on commit.
`timescale 1ns/1ps
module cfg_layer_mux_array #(
    parameter int N       = 125,
    parameter int NCH     = 2,
    parameter int REG_OUT = 0
) (
    input  logic           CLK,
    input  logic           RSTN,
    input  logic [N-1:0]   A,
    input  logic           SIN,
    input  logic           CE,
    input  logic           COMMIT,
    output logic [NCH-1:0] Z,
    output logic           SOUT,
    output logic           CFG_VALID,
    output logic           CFG_ERR
);

    // Number of LUTs in layer m (layer 1 consumes the A bus directly).
    function automatic int layer_size(input int n, input int m);
        int s;
        s = n;
        for (int k = 0; k < m; k++) s = (s + 4) / 5;
        return s;
    endfunction

    function automatic int num_layers(input int n);
        int s;
        int c;
        s = (n + 4) / 5;
        c = 1;
        while (s > 1) begin
            s = (s + 4) / 5;
            c++;
        end
        return c;
    endfunction

    function automatic int total_luts(input int n);
        int s;
        int t;
        s = (n + 4) / 5;
        t = s;
        while (s > 1) begin
            s = (s + 4) / 5;
            t += s;
        end
        return t;
    endfunction

    localparam int NL      = num_layers(N);
    localparam int NLUT    = total_luts(N);
    localparam int L1      = layer_size(N, 1);
    localparam int CH_BITS = NLUT * 32;
    localparam int LEN     = NCH * CH_BITS;
    localparam int CW      = $clog2(LEN + 2);
    localparam logic [CW-1:0] CNT_LEN = CW'(LEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(LEN + 1);

    // Walks the LUTs of one channel in storage order; every layer only reads
    // results of the layer before it, so a single in-order pass suffices.
    function automatic logic eval_tree(input logic [CH_BITS-1:0] cfg,
                                       input logic [N-1:0]       a);
        logic [NLUT-1:0] node;
        logic [4:0]      addr;
        int              j;
        int              prev_base;
        int              prev_cnt;
        int              cur_cnt;
        int              src;
        node      = '0;
        addr      = '0;
        j         = 0;
        prev_base = 0;
        prev_cnt  = 0;
        for (int m = 1; m <= NL; m++) begin
            cur_cnt = layer_size(N, m);
            for (int i = 0; i < L1; i++) begin
                if (i < cur_cnt) begin
                    for (int k = 0; k < 5; k++) begin
                        src = i * 5 + k;
                        if (m == 1)
                            addr[k] = (src < N) ? a[src] : 1'b0;
                        else
                            addr[k] = (src < prev_cnt) ? node[prev_base + src] : 1'b0;
                    end
                    node[j] = cfg[j * 32 + int'(addr)];
                    j++;
                end
            end
            prev_base = j - cur_cnt;
            prev_cnt  = cur_cnt;
        end
        return node[NLUT-1];
    endfunction

    logic [LEN-1:0] shadow_q;
    logic [LEN-1:0] active_q;
    logic [CW-1:0]  cnt_q;
    logic           valid_q;
    logic           err_q;
    logic [NCH-1:0] z_comb;

    // Shadow shifting, commit acceptance/rejection and the saturating bit count.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (COMMIT) begin
            cnt_q <= '0;
            if (cnt_q == CNT_LEN) begin
                active_q <= shadow_q;
                valid_q  <= 1'b1;
                err_q    <= 1'b0;
            end else begin
                err_q <= 1'b1;
            end
        end else begin
            err_q <= 1'b0;
            if (CE) begin
                shadow_q <= {shadow_q[LEN-2:0], SIN};
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // LUT trees evaluated from the active store only.
    always_comb begin
        z_comb = '0;
        for (int c = 0; c < NCH; c++)
            z_comb[c] = eval_tree(active_q[c * CH_BITS +: CH_BITS], A);
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [NCH-1:0] z_q;
            // Output register reloads the tree result every cycle.
            always_ff @(posedge CLK) begin
                if (!RSTN) z_q <= '0;
                else       z_q <= z_comb;
            end
            assign Z = z_q;
        end else begin : g_comb
            assign Z = z_comb;
        end
    endgenerate

    assign SOUT      = shadow_q[LEN-1];
    assign CFG_VALID = valid_q;
    assign CFG_ERR   = err_q;

endmodule

// File: tb/tb_cfg_layer_mux_array.sv
// Scoreboard bench: two instances (N=5/NCH=2 combinational, N=125/NCH=1
// registered). Stimulus pushes expected values; a negedge monitor compares.
`timescale 1ns/1ps
module tb_cfg_layer_mux_array;

    localparam int K_AZ = 0, K_AV = 1, K_AE = 2, K_AS = 3;
    localparam int K_BZ = 4, K_BV = 5, K_BE = 6, K_BS = 7;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: N=5, NCH=2, combinational Z
    logic         a_rstn, a_sin, a_ce, a_commit;
    logic [4:0]   a_a;
    logic [1:0]   a_z;
    logic         a_sout, a_valid, a_err;
    // instance B: N=125, NCH=1, registered Z
    logic         b_rstn, b_sin, b_ce, b_commit;
    logic [124:0] b_a;
    logic [0:0]   b_z;
    logic         b_sout, b_valid, b_err;

    cfg_layer_mux_array #(.N(5), .NCH(2), .REG_OUT(0)) dut_a (
        .CLK(clk), .RSTN(a_rstn), .A(a_a), .SIN(a_sin), .CE(a_ce),
        .COMMIT(a_commit), .Z(a_z), .SOUT(a_sout), .CFG_VALID(a_valid),
        .CFG_ERR(a_err)
    );

    cfg_layer_mux_array #(.N(125), .NCH(1), .REG_OUT(1)) dut_b (
        .CLK(clk), .RSTN(b_rstn), .A(b_a), .SIN(b_sin), .CE(b_ce),
        .COMMIT(b_commit), .Z(b_z), .SOUT(b_sout), .CFG_VALID(b_valid),
        .CFG_ERR(b_err)
    );

    chk_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_chk(input int kind, input logic [31:0] exp, input string name);
        chk_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic shift_a(input logic [63:0] pat, input int n,
                           input logic chk_z, input logic [1:0] zexp);
        for (int i = 0; i < n; i++) begin
            a_sin = (i < 64) ? pat[63 - i] : 1'b0;
            a_ce  = 1'b1;
            step();
            if (chk_z) push_chk(K_AZ, 32'(zexp), "a_z_during_shift");
        end
        a_ce  = 1'b0;
        a_sin = 1'b0;
    endtask

    task automatic commit_a();
        a_commit = 1'b1;
        step();
        a_commit = 1'b0;
    endtask

    // Monitor: compares every queued expectation against the DUT on the falling edge.
    chk_t        mon_e;
    logic [31:0] mon_act;
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                mon_e = sb.pop_front();
                case (mon_e.kind)
                    K_AZ:    mon_act = 32'(a_z);
                    K_AV:    mon_act = 32'(a_valid);
                    K_AE:    mon_act = 32'(a_err);
                    K_AS:    mon_act = 32'(a_sout);
                    K_BZ:    mon_act = 32'(b_z);
                    K_BV:    mon_act = 32'(b_valid);
                    K_BE:    mon_act = 32'(b_err);
                    K_BS:    mon_act = 32'(b_sout);
                    default: mon_act = 32'hFFFF_FFFF;
                endcase
                n_checks++;
                if (mon_act == mon_e.exp) n_pass++;
                else $display("FAIL %s: got %0h, want %0h", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [63:0]  p1;
    logic [63:0]  p2;
    logic [991:0] b_cfg;
    logic [124:0] hot37;
    logic [5:0]   seq;
    logic         prev;

    initial begin
        a_rstn = 1'b0; a_sin = 1'b0; a_ce = 1'b0; a_commit = 1'b0; a_a = '0;
        b_rstn = 1'b0; b_sin = 1'b0; b_ce = 1'b0; b_commit = 1'b0; b_a = '0;
        p1 = 64'hFFFF0000_00000002;
        p2 = 64'h0000FFFF_FFFFFFFE;
        hot37 = '0;
        hot37[37] = 1'b1;
        step();
        step();
        push_chk(K_AZ, 0, "a_reset_z");
        push_chk(K_AV, 0, "a_reset_valid");
        push_chk(K_AE, 0, "a_reset_err");
        push_chk(K_AS, 0, "a_reset_sout");
        push_chk(K_BZ, 0, "b_reset_z");
        push_chk(K_BV, 0, "b_reset_valid");
        push_chk(K_BE, 0, "b_reset_err");
        a_rstn = 1'b1;
        b_rstn = 1'b1;
        step();

        // first configuration and exhaustive sweep of A
        shift_a(p1, 64, 1'b1, 2'b00);
        push_chk(K_AS, 1, "a_sout_after_load");
        push_chk(K_AV, 0, "a_valid_before_commit");
        commit_a();
        push_chk(K_AV, 1, "a_valid_after_commit");
        push_chk(K_AE, 0, "a_err_good_commit");
        for (int v = 0; v < 32; v++) begin
            a_a = 5'(v);
            push_chk(K_AZ, 32'({a_a[4], a_a == 5'b00001}), "a_sweep_z");
            step();
        end

        // reprogram while live: Z must hold until commit
        a_a = 5'b10001;
        push_chk(K_AZ, 32'(2'b10), "a_z_before_reprog");
        shift_a(p2, 64, 1'b1, 2'b10);
        commit_a();
        push_chk(K_AZ, 32'(2'b01), "a_z_after_reprog");
        push_chk(K_AV, 1, "a_valid_after_reprog");

        // short commit
        shift_a(64'h0, 63, 1'b1, 2'b01);
        commit_a();
        push_chk(K_AE, 1, "a_err_short");
        push_chk(K_AZ, 32'(2'b01), "a_z_after_short");
        push_chk(K_AV, 1, "a_valid_after_short");
        step();
        push_chk(K_AE, 0, "a_err_short_pulse_end");

        // overflow commit
        shift_a(64'h0, 65, 1'b0, 2'b00);
        commit_a();
        push_chk(K_AE, 1, "a_err_overflow");
        push_chk(K_AZ, 32'(2'b01), "a_z_after_overflow");
        step();
        push_chk(K_AE, 0, "a_err_overflow_pulse_end");
        push_chk(K_AZ, 32'(2'b01), "a_z_after_overflow2");

        // SOUT timing
        shift_a(64'h80000000_00000000, 63, 1'b0, 2'b00);
        push_chk(K_AS, 0, "a_sout_after_63");
        shift_a(64'h0, 1, 1'b0, 2'b00);
        push_chk(K_AS, 1, "a_sout_after_64");
        shift_a(64'h0, 1, 1'b0, 2'b00);
        push_chk(K_AS, 0, "a_sout_after_65");

        // reset in the middle of a load
        shift_a(p2, 30, 1'b0, 2'b00);
        a_rstn = 1'b0;
        step();
        push_chk(K_AV, 0, "a_valid_mid_reset");
        push_chk(K_AZ, 0, "a_z_mid_reset");
        push_chk(K_AE, 0, "a_err_mid_reset");
        a_rstn = 1'b1;
        shift_a(p2 << 30, 34, 1'b0, 2'b00);
        commit_a();
        push_chk(K_AE, 1, "a_err_after_reset_commit");
        push_chk(K_AZ, 0, "a_z_after_reset_commit");
        push_chk(K_AV, 0, "a_valid_after_reset_commit");

        // instance B: route A[37] through layer1 LUT7 bit2, layer2 LUT1 bit2, root bit1
        for (int j = 0; j < 30; j++) b_cfg[j * 32 +: 32] = 32'hF0F0F0F0;
        b_cfg[960 +: 32] = 32'hCCCCCCCC;
        for (int i = 991; i >= 0; i--) begin
            b_sin = b_cfg[i];
            b_ce  = 1'b1;
            step();
        end
        b_ce  = 1'b0;
        b_sin = 1'b0;
        b_a   = hot37;
        push_chk(K_BS, 1, "b_sout_after_load");
        step();
        push_chk(K_BZ, 0, "b_z_before_commit");
        b_commit = 1'b1;
        step();
        b_commit = 1'b0;
        push_chk(K_BV, 1, "b_valid_after_commit");
        push_chk(K_BE, 0, "b_err_good_commit");
        push_chk(K_BZ, 0, "b_z_commit_edge");
        prev = 1'b1;
        seq  = 6'b010110;
        for (int k = 0; k < 6; k++) begin
            step();
            push_chk(K_BZ, 32'(prev), "b_z_track");
            b_a  = seq[k] ? hot37 : ~hot37;
            prev = seq[k];
        end

        // CE together with COMMIT: rejected, and no shift takes place
        b_a   = hot37;
        b_sin = 1'b0;
        b_ce  = 1'b1;
        step();
        b_ce  = 1'b0;
        push_chk(K_BS, 1, "b_sout_before_ce_commit");
        b_ce     = 1'b1;
        b_commit = 1'b1;
        step();
        b_ce     = 1'b0;
        b_commit = 1'b0;
        push_chk(K_BE, 1, "b_err_ce_commit");
        push_chk(K_BS, 1, "b_sout_no_shift");
        push_chk(K_BV, 1, "b_valid_ce_commit");
        push_chk(K_BZ, 1, "b_z_ce_commit");
        step();
        push_chk(K_BE, 0, "b_err_ce_commit_end");
        push_chk(K_BS, 1, "b_sout_no_shift2");
        b_a = ~hot37;
        step();
        push_chk(K_BZ, 0, "b_z_after_reject");

        step();
        step();
        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
